// File: rtl/mem_init_loader_if.sv
// User-side and memory-side request/ack buses around the init loader.
// master = the loader (it drives the memory port), slave = the surrounding system.
interface mem_init_loader_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          usr_req;
    logic          usr_we;
    logic [AW-1:0] usr_addr;
    logic [DW-1:0] usr_wd;
    logic          usr_ack;
    logic [DW-1:0] usr_rd;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_ack;
    logic [DW-1:0] mem_rd;

    modport master (
        input  usr_req, usr_we, usr_addr, usr_wd, mem_ack, mem_rd,
        output usr_ack, usr_rd, mem_req, mem_we, mem_addr, mem_wd
    );

    modport slave (
        output usr_req, usr_we, usr_addr, usr_wd, mem_ack, mem_rd,
        input  usr_ack, usr_rd, mem_req, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/mem_init_loader.sv
// Owns the memory write port after reset (or on start), writes the {addr,data}
// init table one entry per ack, then hands the port to the user bus.
module mem_init_loader #(
    parameter int ENTRIES    = 8,
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ENTRIES*(AW+DW)-1:0]  init_tbl,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    mem_init_loader_if.master           bus
);
    localparam int EW = AW + DW;
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          arm_q, pend_q, busy_q, done_q, req_q, we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;

    entry_t        ent0, ent_nxt;
    int unsigned   nxt_base;
    logic          user_free;

    assign ent0 = entry_t'(init_tbl[EW-1:0]);

    // Base of entry idx+1; pinned to 0 on the last entry so the select stays in range.
    always_comb begin
        nxt_base = 0;
        if (idx_q != LAST) nxt_base = (int'(idx_q) + 1) * EW;
    end
    assign ent_nxt = entry_t'(init_tbl[nxt_base +: EW]);

    // A reload may only take the port when no user transfer would be cut off.
    assign user_free = !bus.usr_req || bus.mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            arm_q   <= AUTO_START;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start || arm_q) begin
                        state_q <= WRITE;
                        arm_q   <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ent0.addr;
                        wd_q    <= ent0.data;
                    end
                end
                WRITE: begin
                    if (req_q && bus.mem_ack) begin
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            addr_q  <= ent_nxt.addr;
                            wd_q    <= ent_nxt.data;
                        end
                    end
                end
                DONE: begin
                    if ((start || pend_q) && user_free) begin
                        state_q <= WRITE;
                        pend_q  <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ent0.addr;
                        wd_q    <= ent0.data;
                    end else if (start) begin
                        pend_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Once loaded, the memory port is a plain wire-through of the user bus.
    assign bus.mem_req  = (state_q == DONE) ? bus.usr_req  : req_q;
    assign bus.mem_we   = (state_q == DONE) ? bus.usr_we   : we_q;
    assign bus.mem_addr = (state_q == DONE) ? bus.usr_addr : addr_q;
    assign bus.mem_wd   = (state_q == DONE) ? bus.usr_wd   : wd_q;
    assign bus.usr_ack  = (state_q == DONE) && bus.mem_ack;
    assign bus.usr_rd   = (state_q == DONE) ? bus.mem_rd : '0;

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_mem_init_loader.sv
// Bench for mem_init_loader: wait-state memory model, write log and table reference.
module tb_mem_init_loader;
    localparam int E  = 8;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int EW = AW + DW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [E*EW-1:0] tbl;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic busy0, done0, busy1, done1, busy2, done2;

    mem_init_loader_if #(.AW(AW), .DW(DW)) b0 ();
    mem_init_loader_if #(.AW(AW), .DW(DW)) b1 ();
    mem_init_loader_if #(.AW(AW), .DW(DW)) b2 ();

    mem_init_loader #(.ENTRIES(E), .AW(AW), .DW(DW), .AUTO_START(1'b1)) u0 (
        .clk(clk), .rst(rst), .init_tbl(tbl), .start(start0),
        .busy(busy0), .done(done0), .bus(b0));
    mem_init_loader #(.ENTRIES(E), .AW(AW), .DW(DW), .AUTO_START(1'b0)) u1 (
        .clk(clk), .rst(rst), .init_tbl(tbl), .start(start1),
        .busy(busy1), .done(done1), .bus(b1));
    mem_init_loader #(.ENTRIES(1), .AW(AW), .DW(DW), .AUTO_START(1'b1)) u2 (
        .clk(clk), .rst(rst), .init_tbl(tbl[EW-1:0]), .start(start2),
        .busy(busy2), .done(done2), .bus(b2));

    // Memory model for u0: programmable wait states (-1 = random 0..3 per transfer).
    logic [DW-1:0] mem [0:65535];
    int  wait_mode = 0;
    int  wcnt = 0, wcur = 0;
    wr_t log0[$], log1[$], log2[$];

    assign b0.mem_ack = b0.mem_req && (wcnt == wcur);
    assign b0.mem_rd  = mem[b0.mem_addr];
    assign b1.mem_ack = b1.mem_req;
    assign b1.mem_rd  = '0;
    assign b2.mem_ack = b2.mem_req;
    assign b2.mem_rd  = '0;

    always @(posedge clk) begin
        if (b0.mem_req && b0.mem_ack) begin
            if (b0.mem_we) begin
                mem[b0.mem_addr] <= b0.mem_wd;
                log0.push_back({b0.mem_addr, b0.mem_wd});
            end
            wcnt <= 0;
            wcur <= (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end else if (b0.mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            wcur <= (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (b1.mem_req && b1.mem_we) log1.push_back({b1.mem_addr, b1.mem_wd});
        if (b2.mem_req && b2.mem_we) log2.push_back({b2.mem_addr, b2.mem_wd});
    end

    // Protocol monitors: load request held stable until ack; no user ack before done.
    wr_t  prev_w;
    logic chk_hold = 1'b0;
    int   stab_err = 0, uack_err = 0;
    always @(posedge clk) begin
        if (!rst && chk_hold && ({b0.mem_addr, b0.mem_wd} !== prev_w)) stab_err <= stab_err + 1;
        if (!rst && busy0 && b0.mem_req && !b0.mem_ack) begin
            prev_w   <= {b0.mem_addr, b0.mem_wd};
            chk_hold <= 1'b1;
        end else begin
            chk_hold <= 1'b0;
        end
        if (b0.usr_ack && !done0) uack_err <= uack_err + 1;
    end

    logic [AW-1:0] ta [E];
    logic [DW-1:0] td [E];
    int n_run = 0, n_fail = 0;

    task automatic build_tbl();
        for (int i = 0; i < E; i++) tbl[i*EW +: EW] = {ta[i], td[i]};
    endtask

    task automatic wait_done(input int sel, input int bound, output int cyc);
        cyc = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if ((sel == 0 && done0) || (sel == 1 && done1)) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_run++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_run++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
        n_run++; if (b0.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", b0.mem_req); end
        n_run++; if (b0.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", b0.mem_we); end
        n_run++; if (b0.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", b0.mem_addr); end
        n_run++; if (b0.mem_wd !== '0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", b0.mem_wd); end
        n_run++; if (b0.usr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_uack: got %b want 0", b0.usr_ack); end
    endtask

    task automatic test_auto_load();
        int cyc;
        wait_mode = 0;
        log0.delete(); log1.delete(); log2.delete();
        @(negedge clk) rst = 1'b0;
        wait_done(0, 40, cyc);
        n_run++; if (cyc !== 1 + E) begin n_fail++; $display("FAIL auto_cycles: got %0d want %0d", cyc, 1 + E); end
        n_run++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL auto_busy: got %b want 0", busy0); end
        n_run++; if (log0.size() !== E) begin n_fail++; $display("FAIL auto_count: got %0d want %0d", log0.size(), E); end
        for (int i = 0; i < E && i < log0.size(); i++) begin
            n_run++;
            if (log0[i] !== {ta[i], td[i]}) begin
                n_fail++; $display("FAIL auto_entry%0d: got %h want %h", i, log0[i], {ta[i], td[i]});
            end
        end
        n_run++; if (log2.size() !== 1) begin n_fail++; $display("FAIL one_count: got %0d want 1", log2.size()); end
        if (log2.size() > 0) begin
            n_run++; if (log2[0] !== {ta[0], td[0]}) begin n_fail++; $display("FAIL one_entry: got %h want %h", log2[0], {ta[0], td[0]}); end
        end
        n_run++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL one_done: got %b want 1", done2); end
        n_run++; if (log1.size() !== 0) begin n_fail++; $display("FAIL noauto_writes: got %0d want 0", log1.size()); end
    endtask

    task automatic test_wait_user();
        int cyc, ua0, got;
        logic [DW-1:0] ev;
        rst = 1'b1;
        wait_mode = 2;
        @(negedge clk);
        b0.usr_req = 1'b1; b0.usr_we = 1'b0; b0.usr_addr = 16'd3; b0.usr_wd = '0;
        log0.delete();
        ua0 = uack_err;
        rst = 1'b0;
        wait_done(0, 80, cyc);
        n_run++; if (cyc !== 1 + 3*E) begin n_fail++; $display("FAIL wait_cycles: got %0d want %0d", cyc, 1 + 3*E); end
        n_run++; if (log0.size() !== E) begin n_fail++; $display("FAIL wait_count: got %0d want %0d", log0.size(), E); end
        for (int i = 0; i < E && i < log0.size(); i++) begin
            n_run++;
            if (log0[i] !== {ta[i], td[i]}) begin
                n_fail++; $display("FAIL wait_entry%0d: got %h want %h", i, log0[i], {ta[i], td[i]});
            end
        end
        n_run++; if (stab_err !== 0) begin n_fail++; $display("FAIL wait_hold: got %0d changes want 0", stab_err); end
        n_run++; if (uack_err !== ua0) begin n_fail++; $display("FAIL stall_uack: got %0d acks want 0", uack_err - ua0); end
        ev = '0;
        for (int i = 0; i < E; i++) if (ta[i] == 16'd3) ev = td[i];
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (b0.usr_ack) begin got = 1; break; end
            @(negedge clk);
        end
        n_run++; if (got !== 1) begin n_fail++; $display("FAIL user_ack: got %0d want 1", got); end
        n_run++; if (b0.usr_rd !== ev) begin n_fail++; $display("FAIL user_rd: got %h want %h", b0.usr_rd, ev); end
        @(posedge clk); #1;
        b0.usr_req = 1'b0;
    endtask

    task automatic test_reload_deferred();
        int cyc, got;
        logic [DW-1:0] uwd;
        @(negedge clk);
        log0.delete();
        uwd = $urandom;
        b0.usr_req = 1'b1; b0.usr_we = 1'b1; b0.usr_addr = 16'h0100; b0.usr_wd = uwd;
        start0 = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (k == 0) begin
                n_run++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL defer_done: got %b want 1", done0); end
            end
            if (b0.usr_ack) begin got = 1; break; end
        end
        @(posedge clk); #1;
        b0.usr_req = 1'b0; b0.usr_we = 1'b0;
        n_run++; if (got !== 1) begin n_fail++; $display("FAIL defer_uack: got %0d want 1", got); end
        n_run++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL defer_drop: got %b want 0", done0); end
        n_run++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL defer_busy: got %b want 1", busy0); end
        wait_done(0, 100, cyc);
        n_run++; if (cyc < 0) begin n_fail++; $display("FAIL defer_timeout: got %0d want done", cyc); end
        n_run++; if (log0.size() !== E + 1) begin n_fail++; $display("FAIL defer_count: got %0d want %0d", log0.size(), E + 1); end
        if (log0.size() > 0) begin
            n_run++; if (log0[0] !== {16'h0100, uwd}) begin n_fail++; $display("FAIL defer_user: got %h want %h", log0[0], {16'h0100, uwd}); end
        end
        for (int i = 0; i < E && i + 1 < log0.size(); i++) begin
            n_run++;
            if (log0[i+1] !== {ta[i], td[i]}) begin
                n_fail++; $display("FAIL defer_entry%0d: got %h want %h", i, log0[i+1], {ta[i], td[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        wait_mode = 0;
        rst = 1'b1;
        @(negedge clk);
        log0.delete();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (log0.size() >= 4) break;
        end
        n_run++; if (log0.size() !== 4) begin n_fail++; $display("FAIL mid_acks: got %0d want 4", log0.size()); end
        rst = 1'b1;
        #1;
        n_run++; if (b0.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", b0.mem_req); end
        n_run++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy0); end
        n_run++; if ({b0.mem_addr, b0.mem_wd} !== '0) begin n_fail++; $display("FAIL mid_bus: got %h want 0", {b0.mem_addr, b0.mem_wd}); end
        @(negedge clk);
        log0.delete();
        rst = 1'b0;
        wait_done(0, 40, cyc);
        n_run++; if (cyc !== 1 + E) begin n_fail++; $display("FAIL mid_cycles: got %0d want %0d", cyc, 1 + E); end
        n_run++; if (log0.size() !== E) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", log0.size(), E); end
        for (int i = 0; i < E && i < log0.size(); i++) begin
            n_run++;
            if (log0[i] !== {ta[i], td[i]}) begin
                n_fail++; $display("FAIL mid_entry%0d: got %h want %h", i, log0[i], {ta[i], td[i]});
            end
        end
    endtask

    task automatic test_auto_start0();
        int cyc, act;
        log1.delete();
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (b1.mem_req || busy1) act++;
        end
        n_run++; if (act !== 0) begin n_fail++; $display("FAIL idle_req: got %0d active cycles want 0", act); end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 40, cyc);
        n_run++; if (cyc + 1 !== 1 + E) begin n_fail++; $display("FAIL start_cycles: got %0d want %0d", cyc + 1, 1 + E); end
        n_run++; if (log1.size() !== E) begin n_fail++; $display("FAIL start_count: got %0d want %0d", log1.size(), E); end
        for (int i = 0; i < E && i < log1.size(); i++) begin
            n_run++;
            if (log1[i] !== {ta[i], td[i]}) begin
                n_fail++; $display("FAIL start_entry%0d: got %h want %h", i, log1[i], {ta[i], td[i]});
            end
        end
    endtask

    task automatic test_random();
        int cyc, got;
        logic [DW-1:0] ref_mem [int];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic we;
        rst = 1'b1;
        for (int i = 0; i < E; i++) begin
            ta[i] = 16'($urandom_range(0, 15));
            td[i] = $urandom;
        end
        build_tbl();
        wait_mode = -1;
        @(negedge clk);
        log0.delete();
        rst = 1'b0;
        wait_done(0, 200, cyc);
        n_run++; if (cyc < 0) begin n_fail++; $display("FAIL rnd_timeout: got %0d want done", cyc); end
        n_run++; if (log0.size() !== E) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", log0.size(), E); end
        for (int i = 0; i < E && i < log0.size(); i++) begin
            n_run++;
            if (log0[i] !== {ta[i], td[i]}) begin
                n_fail++; $display("FAIL rnd_entry%0d: got %h want %h", i, log0[i], {ta[i], td[i]});
            end
        end
        n_run++; if (stab_err !== 0) begin n_fail++; $display("FAIL rnd_hold: got %0d changes want 0", stab_err); end
        for (int i = 0; i < E; i++) ref_mem[int'(ta[i])] = td[i];
        for (int t = 0; t < 16; t++) begin
            a  = ($urandom_range(0, 1) != 0) ? ta[$urandom_range(0, E-1)] : 16'(16'h0200 + $urandom_range(0, 3));
            we = ($urandom_range(0, 1) != 0) || !ref_mem.exists(int'(a));
            d  = $urandom;
            @(negedge clk);
            b0.usr_req = 1'b1; b0.usr_we = we; b0.usr_addr = a; b0.usr_wd = d;
            got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (b0.usr_ack) begin got = 1; break; end
            end
            n_run++; if (got !== 1) begin n_fail++; $display("FAIL rnd_uack%0d: got %0d want 1", t, got); end
            if (!we) begin
                n_run++;
                if (b0.usr_rd !== ref_mem[int'(a)]) begin
                    n_fail++; $display("FAIL rnd_read%0d: got %h want %h", t, b0.usr_rd, ref_mem[int'(a)]);
                end
            end else begin
                ref_mem[int'(a)] = d;
            end
            @(posedge clk); #1;
            b0.usr_req = 1'b0; b0.usr_we = 1'b0;
        end
    endtask

    initial begin
        b0.usr_req = 1'b0; b0.usr_we = 1'b0; b0.usr_addr = '0; b0.usr_wd = '0;
        b1.usr_req = 1'b0; b1.usr_we = 1'b0; b1.usr_addr = '0; b1.usr_wd = '0;
        b2.usr_req = 1'b0; b2.usr_we = 1'b0; b2.usr_addr = '0; b2.usr_wd = '0;
        td = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hFFFFFFFF,
               32'h55555555, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < E; i++) ta[i] = 16'(i);
        build_tbl();
        test_reset();
        test_auto_load();
        test_wait_user();
        test_reload_deferred();
        test_reset_mid();
        test_auto_start0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_init_loader.md
Name: mem_init_loader

Overview:
- Sits directly upstream of the memory module and owns the memory's write port until the memory has been initialised.
- After reset, or on request, it walks a table of {address, data} pairs and issues one write transaction per entry into the memory.
- Once the table is exhausted, it hands the memory port to the user bus as a pass-through.
- The table is the memory init-vector constant, flattened and driven from the integrator's level.

Parameters:
- ENTRIES, 8, number of table entries (>=1).
- AW, 16, address field width.
- DW, 32, data field width.
- AUTO_START, 1, 1 = start loading automatically after reset release; 0 = wait for start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- init_tbl  in  ENTRIES*(AW+DW)  flattened table, static. Entry i occupies bits [(i+1)*(AW+DW)-1 : i*(AW+DW)]. Within an entry, addr is the top AW bits and data is the low DW bits.
- start  in  1  single-cycle (re)load request.
- busy  out  1  loading in progress.
- done  out  1  table fully written; user bus granted.
- usr_req  in  1  user request.
- usr_we  in  1  user write enable.
- usr_addr  in  AW  user address.
- usr_wd  in  DW  user write data.
- usr_ack  out  1  user acknowledge.
- usr_rd  out  DW  user read data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_ack  in  1  memory acknowledge.
- mem_rd  in  DW  memory read data.

Behaviour:
- States: IDLE, WRITE, DONE. Entry index idx has width clog2(ENTRIES), minimum 1 bit. arm is a one-shot auto-start flag.
- Reset (async, any time, including mid-WRITE):
  - state=IDLE, idx=0, arm=AUTO_START.
  - busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Loading restarts from entry 0 afterwards; partial writes are not undone.
- IDLE:
  - mem_req=0, usr_ack=0, usr_rd=0.
  - On start=1 or arm=1: go to WRITE, clear arm, register entry 0 onto mem_addr/mem_wd.
  - With AUTO_START=1, the first write request appears on the 2nd rising edge after rst deasserts (mem_req high from cycle 1 after the IDLE cycle).
- WRITE:
  - busy=1; mem_req=1 and mem_we=1, registered.
  - mem_addr/mem_wd hold entry idx until mem_ack=1 is sampled with mem_req=1.
  - On ack with idx<ENTRIES-1: idx+1 and the next entry is registered; mem_req stays high. A zero-wait memory therefore takes one write per cycle and ENTRIES cycles total.
  - On ack with idx==ENTRIES-1: idx=0, go to DONE, mem_req drops next cycle.
  - start is ignored in this state.
  - usr_ack=0 and the user bus is stalled; the user holds usr_req until acked.
- DONE:
  - done=1, busy=0.
  - Combinational pass-through: mem_req=usr_req, mem_we=usr_we, mem_addr=usr_addr, mem_wd=usr_wd, usr_ack=mem_ack, usr_rd=mem_rd.
  - start=1 is accepted only when the user bus is idle that cycle (usr_req=0) or completing (usr_req=1 and mem_ack=1). Otherwise it is latched as pending and taken at the first such cycle. This prevents abandoning an in-flight user transfer.
  - On acceptance: go to WRITE from entry 0; done drops the next cycle.
- Outside DONE: usr_ack=0 and usr_rd=0.
- done stays high until a re-load is accepted or reset.
- ENTRIES=1: WRITE lasts until the single ack, then DONE.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- AUTO_START=1, default table (entry0 {0x0000, AAAAAAAA} … entry7 {0x0007, 11111111}), mem_ack tied 1 -> after rst drop, 8 consecutive write cycles with addresses 0..7 and matching data, in entry order. done=1 on the cycle after the 8th ack; busy=0.
- Memory inserts 2 wait cycles per write -> each addr/data is held stable for 3 cycles with mem_req=1; 24 loading cycles in total; no entry skipped or repeated.
- usr_req=1, usr_we=0, usr_addr=3 asserted during WRITE -> usr_ack=0 throughout loading. After done, the read returns 0xFFFFFFFF via usr_rd with usr_ack=1.
- start pulsed in DONE while a user write is waiting for ack -> reload is deferred until that ack. The user write completes once, then entries 0..7 are rewritten and done re-asserts.
- rst asserted after the 4th ack -> outputs return to reset values immediately. After release, loading restarts at addr 0; all 8 entries are rewritten.
- AUTO_START=0 -> stays in IDLE with mem_req=0 for 20 cycles. A start pulse then triggers the full 8-entry load.
